// File: rtl/i2c_pkg.sv
// Shared types for the I2C target responder: transfer state encoding and R/W bit meaning.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrite,
    StWrAck,
    StRead,
    StRdAck,
    StIgnore
  } i2c_state_e;

  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_in_filter.sv
// Two-flop synchroniser plus stability filter for one I2C line; emits the accepted level and
// single-cycle rise/fall pulses aligned with the level change.
module i2c_in_filter #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic            settle;

  // A new synced level is accepted once it has been seen on FILT_LEN consecutive edges.
  assign settle = (sync_q[1] != level) && (cnt_q == CntW'(FILT_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      level  <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin};
      rise   <= settle & sync_q[1];
      fall   <= settle & ~sync_q[1];
      if ((sync_q[1] == level) || settle) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (settle) begin
        level <= sync_q[1];
      end
    end
  end

endmodule

// File: rtl/i2c_target_resp.sv
// I2C target: filters SCL/SDA, detects START/STOP, matches a 7-bit address, ACKs written bytes
// and serves read bytes from tx_data. Only ever pulls SDA low; never touches SCL.
module i2c_target_resp
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TGT_ADDR = 7'h28,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       addr_hit,
  output logic       rd_mode,
  output logic       stop_det
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_in_filter #(
    .FILT_LEN(FILT_LEN)
  ) u_scl_filt (
    .clk  (clk),
    .rst  (rst),
    .pin  (scl_i),
    .level(scl_lvl),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_in_filter #(
    .FILT_LEN(FILT_LEN)
  ) u_sda_filt (
    .clk  (clk),
    .rst  (rst),
    .pin  (sda_i),
    .level(sda_lvl),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  logic start_evt, stop_evt;

  assign start_evt = sda_fall & scl_lvl;
  assign stop_evt  = sda_rise & scl_lvl;

  i2c_state_e state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
      sda_oe    <= 1'b0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      addr_hit  <= 1'b0;
      rd_mode   <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      stop_det <= 1'b0;
      // Bus events take priority over any SCL edge seen in the same cycle.
      if (start_evt) begin
        state_q   <= StAddr;
        bit_cnt_q <= 3'd0;
        sda_oe    <= 1'b0;
        addr_hit  <= 1'b0;
      end else if (stop_evt) begin
        state_q  <= StIdle;
        sda_oe   <= 1'b0;
        addr_hit <= 1'b0;
        stop_det <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: ;

          StAddr: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[5:0], sda_lvl};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (shift_q == TGT_ADDR) begin
                  state_q <= StAddrAck;
                  rd_mode <= sda_lvl;
                end else begin
                  state_q <= StIgnore;
                end
              end
            end
          end

          // sda_oe doubles as the ACK phase: first fall starts the ACK, second fall ends it.
          StAddrAck: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe   <= 1'b1;
                addr_hit <= 1'b1;
              end else if (rd_mode == I2C_RW_READ) begin
                tx_load   <= 1'b1;
                shift_q   <= tx_data[6:0];
                sda_oe    <= ~tx_data[7];
                bit_cnt_q <= 3'd0;
                state_q   <= StRead;
              end else begin
                sda_oe  <= 1'b0;
                state_q <= StWrite;
              end
            end
          end

          StWrite: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[5:0], sda_lvl};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                rx_data  <= {shift_q, sda_lvl};
                rx_valid <= 1'b1;
                state_q  <= StWrAck;
              end
            end
          end

          StWrAck: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                state_q <= StWrite;
              end
            end
          end

          StRead: begin
            if (scl_fall) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                sda_oe  <= 1'b0;
                state_q <= StRdAck;
              end else begin
                sda_oe  <= ~shift_q[6];
                shift_q <= {shift_q[5:0], 1'b0};
              end
            end
          end

          // A NACK leaves before the next fall, so reaching a fall here means ACK.
          StRdAck: begin
            if (scl_rise && sda_lvl) begin
              state_q <= StIgnore;
            end else if (scl_fall) begin
              tx_load   <= 1'b1;
              shift_q   <= tx_data[6:0];
              sda_oe    <= ~tx_data[7];
              bit_cnt_q <= 3'd0;
              state_q   <= StRead;
            end
          end

          StIgnore: sda_oe <= 1'b0;

          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_resp.sv
// Bench for i2c_target_resp: a bit-banged controller on a wired-AND bus, with queues holding the
// bytes the target should deliver and the bytes the controller should read back.
module tb_i2c_target_resp;

  localparam int unsigned QSlow = 11;  // quarter bit in clk cycles, ~100 kHz at 4.5 MHz
  localparam int unsigned QFast = 4;   // fastest rate the ACK turnaround of this clock allows

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m, glt;
  logic       scl_bus, sda_bus;
  logic [7:0] tx_data;
  logic       sda_oe, rx_valid, tx_load, addr_hit, rd_mode, stop_det;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  assign scl_bus = scl_m ^ glt;
  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_resp #(
    .TGT_ADDR(7'h28),
    .FILT_LEN(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl_bus),
    .sda_i   (sda_bus),
    .sda_oe  (sda_oe),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_load (tx_load),
    .addr_hit(addr_hit),
    .rd_mode (rd_mode),
    .stop_det(stop_det)
  );

  int checks = 0;
  int errors = 0;
  int n_rx = 0, n_txl = 0, n_stop = 0, n_pull = 0, n_hit = 0;
  int q = QSlow;

  logic [7:0] rx_exp[$];
  logic [7:0] rd_exp[$];
  logic [7:0] tx_src[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: scoreboard for written bytes, event counters, tx_data supply.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid) begin
        n_rx++;
        if (rx_exp.size() == 0) check_eq("rx_unexpected", 32'd1, 32'd0);
        else check_eq("rx_data", {24'd0, rx_data}, {24'd0, rx_exp.pop_front()});
      end
      if (tx_load) begin
        n_txl++;
        if (tx_src.size() > 0) void'(tx_src.pop_front());
      end
      if (stop_det) n_stop++;
      if (sda_oe) n_pull++;
      if (addr_hit) n_hit++;
    end
    tx_data = (tx_src.size() > 0) ? tx_src[0] : 8'h00;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period: data set a quarter into low, sampled at the end of high.
  task automatic bit_xfer(input logic b, input logic glitch, output logic seen);
    sda_m = b;
    clks(q);
    scl_m = 1'b1;
    if (glitch) begin
      clks(q - 1);
      glt = 1'b1;
      clks(1);
      glt = 1'b0;
      clks(q);
    end else begin
      clks(2 * q);
    end
    seen  = sda_bus;
    scl_m = 1'b0;
    clks(q);
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic glitch, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], glitch, s);
    bit_xfer(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 1'b0, s);
      d[i] = s;
    end
    bit_xfer(nack, 1'b0, s);
  endtask

  task automatic i2c_start();
    if (scl_m == 1'b0) begin
      sda_m = 1'b1;
      clks(q);
      scl_m = 1'b1;
      clks(2 * q);
    end
    sda_m = 1'b0;
    clks(2 * q);
    scl_m = 1'b0;
    clks(q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    clks(q);
    scl_m = 1'b1;
    clks(2 * q);
    sda_m = 1'b1;
    clks(2 * q);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int b_rx, b_txl, b_stop, b_pull, b_hit;

    scl_m = 1'b1;
    sda_m = 1'b1;
    glt   = 1'b0;
    rst   = 1'b0;
    clks(3);
    check_eq("rst_sda_oe", sda_oe, 0);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_tx_load", tx_load, 0);
    check_eq("rst_addr_hit", addr_hit, 0);
    check_eq("rst_rd_mode", rd_mode, 0);
    check_eq("rst_stop_det", stop_det, 0);
    rst = 1'b1;
    clks(10);

    // 1: write two bytes then STOP
    q = QSlow;
    b_rx = n_rx; b_stop = n_stop;
    i2c_start();
    wr_byte(8'h50, 1'b0, ack);
    check_eq("t1_addr_ack", ack, 1);
    check_eq("t1_addr_hit", addr_hit, 1);
    check_eq("t1_rd_mode", rd_mode, 0);
    rx_exp.push_back(8'hA5);
    wr_byte(8'hA5, 1'b0, ack);
    check_eq("t1_ack1", ack, 1);
    rx_exp.push_back(8'h3C);
    wr_byte(8'h3C, 1'b0, ack);
    check_eq("t1_ack2", ack, 1);
    i2c_stop();
    clks(10);
    check_eq("t1_rx_count", n_rx - b_rx, 2);
    check_eq("t1_stop_count", n_stop - b_stop, 1);
    check_eq("t1_addr_hit_cleared", addr_hit, 0);

    // 2: read two bytes, ACK then NACK
    b_txl = n_txl;
    tx_src.push_back(8'h12); rd_exp.push_back(8'h12);
    tx_src.push_back(8'h34); rd_exp.push_back(8'h34);
    clks(2);
    i2c_start();
    wr_byte(8'h51, 1'b0, ack);
    check_eq("t2_addr_ack", ack, 1);
    check_eq("t2_rd_mode", rd_mode, 1);
    rd_byte(1'b0, d);
    check_eq("t2_byte0", d, rd_exp.pop_front());
    rd_byte(1'b1, d);
    check_eq("t2_byte1", d, rd_exp.pop_front());
    check_eq("t2_sda_released", sda_oe, 0);
    b_pull = n_pull;
    i2c_stop();
    clks(10);
    check_eq("t2_no_pull_after_nack", n_pull - b_pull, 0);
    check_eq("t2_tx_load_count", n_txl - b_txl, 2);

    // 3: wrong address is ignored
    b_rx = n_rx; b_txl = n_txl; b_pull = n_pull; b_hit = n_hit;
    i2c_start();
    wr_byte(8'h52, 1'b0, ack);
    check_eq("t3_addr_nack", ack, 0);
    wr_byte(8'h77, 1'b0, ack);
    check_eq("t3_data_nack", ack, 0);
    i2c_stop();
    clks(10);
    check_eq("t3_no_pull", n_pull - b_pull, 0);
    check_eq("t3_no_hit", n_hit - b_hit, 0);
    check_eq("t3_no_rx", n_rx - b_rx, 0);
    check_eq("t3_no_tx_load", n_txl - b_txl, 0);

    // 4: write, repeated START, read one byte
    b_rx = n_rx; b_txl = n_txl;
    tx_src.push_back(8'h9C); rd_exp.push_back(8'h9C);
    i2c_start();
    wr_byte(8'h50, 1'b0, ack);
    check_eq("t4_wr_addr_ack", ack, 1);
    check_eq("t4_rd_mode_wr", rd_mode, 0);
    rx_exp.push_back(8'h01);
    wr_byte(8'h01, 1'b0, ack);
    check_eq("t4_data_ack", ack, 1);
    i2c_start();
    wr_byte(8'h51, 1'b0, ack);
    check_eq("t4_rd_addr_ack", ack, 1);
    check_eq("t4_rd_mode_rd", rd_mode, 1);
    check_eq("t4_addr_hit", addr_hit, 1);
    rd_byte(1'b1, d);
    check_eq("t4_rd_byte", d, rd_exp.pop_front());
    i2c_stop();
    clks(10);
    check_eq("t4_rx_count", n_rx - b_rx, 1);
    check_eq("t4_tx_load_count", n_txl - b_txl, 1);

    // 5: fast clock with 1-clk SCL glitches in the data byte
    q = QFast;
    b_rx = n_rx;
    i2c_start();
    wr_byte(8'h50, 1'b0, ack);
    check_eq("t5_addr_ack", ack, 1);
    rx_exp.push_back(8'hC3);
    wr_byte(8'hC3, 1'b1, ack);
    check_eq("t5_data_ack", ack, 1);
    i2c_stop();
    clks(10);
    check_eq("t5_rx_count", n_rx - b_rx, 1);

    // 6: reset while the target drives a 0 in a read
    q = QSlow;
    tx_src.push_back(8'h00);
    clks(2);
    i2c_start();
    wr_byte(8'h51, 1'b0, ack);
    check_eq("t6_addr_ack", ack, 1);
    check_eq("t6_driving_zero", sda_oe, 1);
    rst = 1'b0;
    #1;
    check_eq("t6_async_release", sda_oe, 0);
    clks(1);
    check_eq("t6_addr_hit", addr_hit, 0);
    check_eq("t6_rd_mode", rd_mode, 0);
    check_eq("t6_rx_data", rx_data, 0);
    check_eq("t6_pulses", {29'd0, rx_valid, tx_load, stop_det}, 0);
    clks(2);
    rst   = 1'b1;
    sda_m = 1'b1;
    scl_m = 1'b1;
    clks(20);

    check_eq("rx_scoreboard_empty", rx_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
